unidade_controle_jogo: RTL and testbench



---
 rtl/unidade_controle_jogo.sv | 129 ++++++++++++
 tb/tb_unidade_controle_jogo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_jogo.sv
// Moore control unit for the 16-step sequence-check game: sequences the counter/register
// datapath, detects move-button edges and abandons the round if a move takes too long.
module unidade_controle_jogo #(
    parameter int TIMEOUT = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    localparam logic [3:0] INICIAL     = 4'h0;
    localparam logic [3:0] PREPARACAO  = 4'h1;
    localparam logic [3:0] ESPERA      = 4'h2;
    localparam logic [3:0] REGISTRA    = 4'h4;
    localparam logic [3:0] COMPARACAO  = 4'h5;
    localparam logic [3:0] PROXIMO     = 4'h6;
    localparam logic [3:0] FIM_ACERTO  = 4'hA;
    localparam logic [3:0] FIM_TIMEOUT = 4'hD;
    localparam logic [3:0] FIM_ERRO    = 4'hE;

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    logic [3:0]    estado_q;
    logic [3:0]    estado_d;
    logic          jogada_q;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          borda;

    // Only a rising edge seen while waiting is a move; others are simply dropped.
    assign borda = jogada & ~jogada_q & (estado_q == ESPERA);

    always_comb begin
        estado_d = INICIAL;
        case (estado_q)
            INICIAL:     estado_d = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:  estado_d = ESPERA;
            ESPERA: begin
                if (borda)
                    estado_d = REGISTRA;
                else if (timer_q == TIMER_LAST)
                    estado_d = FIM_TIMEOUT;
                else
                    estado_d = ESPERA;
            end
            REGISTRA:    estado_d = COMPARACAO;
            COMPARACAO: begin
                if (!igual)
                    estado_d = FIM_ERRO;
                else if (fimC)
                    estado_d = FIM_ACERTO;
                else
                    estado_d = PROXIMO;
            end
            PROXIMO:     estado_d = ESPERA;
            FIM_ACERTO:  estado_d = iniciar ? PREPARACAO : FIM_ACERTO;
            FIM_TIMEOUT: estado_d = iniciar ? PREPARACAO : FIM_TIMEOUT;
            FIM_ERRO:    estado_d = iniciar ? PREPARACAO : FIM_ERRO;
            default:     estado_d = INICIAL;
        endcase
    end

    // Timer counts only while staying in espera, so every new visit restarts from zero.
    always_comb begin
        timer_d = '0;
        if (estado_q == ESPERA && estado_d == ESPERA)
            timer_d = timer_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
            jogada_q <= 1'b0;
            timer_q  <= '0;
        end else begin
            estado_q <= estado_d;
            jogada_q <= jogada;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (estado_q)
            PREPARACAO: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            REGISTRA:   registraR = 1'b1;
            PROXIMO:    contaC = 1'b1;
            FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed bench for unidade_controle_jogo with TIMEOUT=8 and a small counter stand-in.
module tb_unidade_controle_jogo;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       jogada = 1'b0;
    logic       igual = 1'b1;
    logic       fimC;
    logic       zeraC, contaC, zeraR, registraR;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    int checks = 0;
    int failures = 0;
    int n_conta = 0;
    int n_registra = 0;
    int cnt = 0;

    unidade_controle_jogo #(.TIMEOUT(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .jogada    (jogada),
        .igual     (igual),
        .fimC      (fimC),
        .zeraC     (zeraC),
        .contaC    (contaC),
        .zeraR     (zeraR),
        .registraR (registraR),
        .pronto    (pronto),
        .acertou   (acertou),
        .errou     (errou),
        .timeout   (timeout),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    // Stand-in for the datapath counter: cleared by zeraC, advanced by contaC.
    always @(posedge clock) begin
        if (zeraC)
            cnt <= 0;
        else if (contaC)
            cnt <= cnt + 1;
    end
    assign fimC = (cnt == 15);

    function automatic logic [7:0] outs();
        return {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (contaC) n_conta++;
        if (registraR) n_registra++;
        $display("t=%0t estado=%h outs=%b cnt=%0d", $time, db_estado, outs(), cnt);
    endtask

    // One move from espera; final_code=0 means the round should continue.
    task automatic move(input logic ig, input logic [3:0] final_code);
        igual  = ig;
        jogada = 1'b1;
        step();
        check("mv_registra", db_estado, 4'h4);
        check("mv_registraR", outs(), 8'b0001_0000);
        jogada = 1'b0;
        step();
        check("mv_comparacao", db_estado, 4'h5);
        step();
        if (final_code != 4'h0) begin
            check("mv_final", db_estado, final_code);
        end else begin
            check("mv_proximo", db_estado, 4'h6);
            check("mv_contaC", outs(), 8'b0100_0000);
            step();
            check("mv_espera", db_estado, 4'h2);
        end
    endtask

    task automatic start_round();
        iniciar = 1'b1;
        step();
        check("st_prep", db_estado, 4'h1);
        check("st_prep_outs", outs(), 8'b1010_0000);
        iniciar = 1'b0;
        step();
        check("st_espera", db_estado, 4'h2);
    endtask

    initial begin
        // Reset with jogada and iniciar held high.
        reset = 1'b1; jogada = 1'b1; iniciar = 1'b1;
        step();
        step();
        check("rst_estado", db_estado, 4'h0);
        check("rst_outs", outs(), 8'h00);
        reset = 1'b0;
        step();
        check("rel_prep", db_estado, 4'h1);
        iniciar = 1'b0;
        step();
        check("rel_espera", db_estado, 4'h2);
        for (int i = 0; i < 3; i++) begin
            step();
            check("held_jogada_no_edge", db_estado, 4'h2);
        end
        jogada = 1'b0;
        step();

        // Full win.
        n_conta = 0; n_registra = 0;
        for (int m = 1; m <= 16; m++)
            move(1'b1, (m == 16) ? 4'hA : 4'h0);
        check("win_outs", outs(), 8'b0000_1100);
        check("win_contaC_pulses", n_conta, 15);
        check("win_registraR_pulses", n_registra, 16);
        step();
        check("win_hold", db_estado, 4'hA);

        // Wrong move on the third move.
        start_round();
        n_conta = 0;
        move(1'b1, 4'h0);
        move(1'b1, 4'h0);
        move(1'b0, 4'hE);
        check("err_outs", outs(), 8'b0000_1010);
        check("err_contaC_pulses", n_conta, 2);

        // Timeout with no jogada.
        start_round();
        for (int i = 0; i < 7; i++) step();
        check("to_still_espera", db_estado, 4'h2);
        step();
        check("to_estado", db_estado, 4'hD);
        check("to_outs", outs(), 8'b0000_1001);

        // Edge on the last espera cycle beats the timeout.
        start_round();
        for (int i = 0; i < 7; i++) step();
        igual = 1'b1;
        jogada = 1'b1;
        step();
        check("edge_wins", db_estado, 4'h4);
        jogada = 1'b0;
        step();
        step();
        check("edge_proximo", db_estado, 4'h6);
        step();
        check("edge_back_espera", db_estado, 4'h2);

        // Mid-round reset while in comparacao.
        jogada = 1'b1;
        step();
        jogada = 1'b0;
        step();
        check("mr_comparacao", db_estado, 4'h5);
        reset = 1'b1;
        step();
        check("mr_rst_estado", db_estado, 4'h0);
        check("mr_rst_outs", outs(), 8'h00);
        reset = 1'b0;
        jogada = 1'b1;
        step();
        check("mr_jogada_ignored", db_estado, 4'h0);
        jogada = 1'b0;
        step();
        check("mr_still_inicial", db_estado, 4'h0);
        iniciar = 1'b1;
        step();
        check("mr_restart_prep", db_estado, 4'h1);
        check("mr_restart_zeraC", zeraC, 1'b1);
        iniciar = 1'b0;
        step();
        check("mr_restart_espera", db_estado, 4'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
